// File: rtl/parc_mem_arbiter_pkg.sv
// Shared definitions for the imem/dmem memory arbiter: message widths and port IDs.
package parc_mem_arbiter_pkg;

  // Request: type(1) + addr(32) + len(2) + data(32); response: type(1) + len(2) + data(32)
  localparam int unsigned MEM_REQ_MSG_SZ  = 67;
  localparam int unsigned MEM_RESP_MSG_SZ = 35;

  localparam logic PARC_MEMARB_IMEM = 1'b0;
  localparam logic PARC_MEMARB_DMEM = 1'b1;

  typedef enum logic {
    PORT_IMEM = PARC_MEMARB_IMEM,
    PORT_DMEM = PARC_MEMARB_DMEM
  } port_id_e;

  typedef logic [MEM_REQ_MSG_SZ-1:0]  mem_req_msg_t;
  typedef logic [MEM_RESP_MSG_SZ-1:0] mem_resp_msg_t;

endpackage

// File: rtl/parc_mem_route_fifo.sv
// Route FIFO: remembers which core port issued each in-flight memory request.
module parc_mem_route_fifo
  import parc_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  port_id_e                 push_id,
  input  logic                     pop,
  output port_id_e                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  port_id_e        mem_q [DEPTH];
  port_id_e        mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= PORT_IMEM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/parc_mem_arbiter.sv
// Round-robin merge of the core's imem and dmem request ports onto one memory port,
// with in-order responses steered back to the issuing port.
module parc_mem_arbiter
  import parc_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MEM_REQ_MSG_SZ-1:0]   imemreq_msg,
  input  logic                        imemreq_val,
  output logic                        imemreq_rdy,
  output logic [MEM_RESP_MSG_SZ-1:0]  imemresp_msg,
  output logic                        imemresp_val,
  input  logic [MEM_REQ_MSG_SZ-1:0]   dmemreq_msg,
  input  logic                        dmemreq_val,
  output logic                        dmemreq_rdy,
  output logic [MEM_RESP_MSG_SZ-1:0]  dmemresp_msg,
  output logic                        dmemresp_val,
  output logic [MEM_REQ_MSG_SZ-1:0]   memreq_msg,
  output logic                        memreq_val,
  input  logic                        memreq_rdy,
  input  logic [MEM_RESP_MSG_SZ-1:0]  memresp_msg,
  input  logic                        memresp_val,
  output logic                        route_err
);

  port_id_e last_grant_q, last_grant_d;
  port_id_e hold_id_q, hold_id_d;
  logic     hold_q, hold_d;
  logic     route_err_q, route_err_d;

  port_id_e                        head;
  port_id_e                        grant_id;
  logic                            fifo_full, fifo_empty;
  logic [$clog2(MAX_INFLIGHT):0]   route_count;
  logic                            grant_dmem, grant_imem, held_live, fire, pop;

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign route_err    = route_err_q;

  always_comb begin
    // A request stalled by memreq_rdy keeps its grant until it fires
    held_live  = hold_q & ((hold_id_q == PORT_DMEM) ? dmemreq_val : imemreq_val);
    if (held_live) grant_dmem = (hold_id_q == PORT_DMEM);
    else           grant_dmem = dmemreq_val & (~imemreq_val | (last_grant_q == PORT_IMEM));
    grant_imem = imemreq_val & ~grant_dmem;
    grant_id   = grant_dmem ? PORT_DMEM : PORT_IMEM;

    memreq_val  = reset & (imemreq_val | dmemreq_val) & ~fifo_full;
    memreq_msg  = grant_dmem ? dmemreq_msg : imemreq_msg;
    imemreq_rdy = reset & grant_imem & memreq_rdy & ~fifo_full;
    dmemreq_rdy = reset & grant_dmem & memreq_rdy & ~fifo_full;
    fire        = memreq_val & memreq_rdy;

    pop          = reset & memresp_val & ~fifo_empty;
    imemresp_val = pop & (head == PORT_IMEM);
    dmemresp_val = pop & (head == PORT_DMEM);

    last_grant_d = fire ? grant_id : last_grant_q;
    hold_d       = memreq_val & ~memreq_rdy;
    hold_id_d    = grant_id;
    route_err_d  = route_err_q | (memresp_val & (route_count == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= PORT_IMEM;
      hold_q       <= 1'b0;
      hold_id_q    <= PORT_IMEM;
      route_err_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      route_err_q  <= route_err_d;
    end
  end

  parc_mem_route_fifo #(.DEPTH(MAX_INFLIGHT)) u_route_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (grant_id),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (route_count)
  );

endmodule

// File: tb/tb_parc_mem_arbiter.sv
// Scoreboard bench for parc_mem_arbiter: reference arbiter model plus a simple in-order memory.
module tb_parc_mem_arbiter;
  import parc_mem_arbiter_pkg::*;

  localparam int unsigned MAXI = 4;

  logic          clk = 1'b0;
  logic          reset;
  mem_req_msg_t  imemreq_msg, dmemreq_msg, memreq_msg;
  mem_resp_msg_t imemresp_msg, dmemresp_msg, memresp_msg;
  logic imemreq_val, imemreq_rdy, imemresp_val;
  logic dmemreq_val, dmemreq_rdy, dmemresp_val;
  logic memreq_val, memreq_rdy, memresp_val, route_err;

  parc_mem_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .route_err(route_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; mem_resp_msg_t data; } exp_t;
  typedef struct { mem_resp_msg_t msg; int unsigned rdy_cyc; } mresp_t;

  exp_t         sb[$];
  mresp_t       mem_pend[$];
  mem_req_msg_t iq[$], dq[$];

  int          checks = 0, failures = 0;
  int unsigned cyc = 0, fires = 0, i_resp = 0, d_resp = 0, lat = 1;
  int          budget = -1;
  logic [7:0]  ord = '0;
  logic        last_fire_d = 1'b0;
  bit          d_en = 1'b1, spur = 1'b0;

  int unsigned cnt_m;
  logic        last_m, hold_m, hold_id_m, err_m;

  task automatic check_eq(input string tag, input logic [MEM_REQ_MSG_SZ-1:0] act,
                          input logic [MEM_REQ_MSG_SZ-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic mem_resp_msg_t resp_of(input mem_req_msg_t r);
    return {r[66], r[33:32], r[65:34] ^ 32'h5A5A_0000};
  endfunction

  function automatic mem_req_msg_t mk_req(input logic typ, input logic [31:0] addr,
                                          input logic [31:0] data);
    return {typ, addr, 2'b00, data};
  endfunction

  task automatic model_reset();
    cnt_m = 0; last_m = 1'b0; hold_m = 1'b0; hold_id_m = 1'b0; err_m = 1'b0;
    sb.delete(); iq.delete(); dq.delete();
  endtask

  // Entered and left at posedge+1: drive, compare before the next edge, then advance the model.
  task automatic cycle();
    logic gd, gi, ev, full_m, pop_m, fire_m, act_fire, from_pend, eid;
    mem_req_msg_t act_msg;
    from_pend = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
    if (spur) begin
      memresp_val = 1'b1; memresp_msg = 35'h1_2345_6789; spur = 1'b0;
    end else if (mem_pend.size() > 0 && mem_pend[0].rdy_cyc <= cyc && budget != 0) begin
      memresp_val = 1'b1; memresp_msg = mem_pend[0].msg; from_pend = 1'b1;
    end
    imemreq_val = (iq.size() > 0);
    imemreq_msg = '0;
    if (iq.size() > 0) imemreq_msg = iq[0];
    dmemreq_val = d_en && (dq.size() > 0);
    dmemreq_msg = '0;
    if (dq.size() > 0) dmemreq_msg = dq[0];
    #4;
    full_m = (cnt_m == MAXI);
    if (hold_m && (hold_id_m ? dmemreq_val : imemreq_val)) gd = hold_id_m;
    else gd = dmemreq_val & (!imemreq_val | (last_m == 1'b0));
    gi = imemreq_val & !gd;
    ev = (imemreq_val | dmemreq_val) & !full_m;
    check_eq("memreq_val", memreq_val, ev);
    if (ev) check_eq("memreq_msg", memreq_msg, gd ? dmemreq_msg : imemreq_msg);
    check_eq("imemreq_rdy", imemreq_rdy, gi & memreq_rdy & !full_m);
    check_eq("dmemreq_rdy", dmemreq_rdy, gd & memreq_rdy & !full_m);
    pop_m = memresp_val && (cnt_m > 0);
    eid = pop_m ? sb[0].id : 1'b0;
    check_eq("imemresp_val", imemresp_val, pop_m && !eid);
    check_eq("dmemresp_val", dmemresp_val, pop_m && eid);
    if (pop_m) check_eq("resp_msg", eid ? dmemresp_msg : imemresp_msg, sb[0].data);
    check_eq("route_err", route_err, err_m);
    act_fire = memreq_val & memreq_rdy;
    act_msg  = memreq_msg;
    if (act_fire) begin
      fires++; ord = {ord[6:0], dmemreq_rdy}; last_fire_d = dmemreq_rdy;
    end
    i_resp += imemresp_val;
    d_resp += dmemresp_val;
    fire_m = ev & memreq_rdy;
    @(posedge clk);
    if (from_pend) begin
      void'(mem_pend.pop_front());
      if (budget > 0) budget--;
    end
    if (act_fire) mem_pend.push_back('{resp_of(act_msg), cyc + lat});
    if (pop_m) void'(sb.pop_front());
    if (fire_m) begin
      sb.push_back('{gd, resp_of(gd ? dmemreq_msg : imemreq_msg)});
      last_m = gd;
      if (gd) void'(dq.pop_front());
      else    void'(iq.pop_front());
    end
    hold_m = ev & !memreq_rdy;
    hold_id_m = gd;
    if (memresp_val && cnt_m == 0) err_m = 1'b1;
    if (fire_m && !pop_m) cnt_m++;
    if (pop_m && !fire_m) cnt_m--;
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (sb.size() > 0 || iq.size() > 0 || dq.size() > 0 || mem_pend.size() > 0); k++)
      cycle();
    check_eq("drain_empty", sb.size() + iq.size() + dq.size() + mem_pend.size(), 0);
  endtask

  task automatic do_async_reset();
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_route_err", route_err, 0);
    check_eq("rst_count", dut.route_count, 0);
    check_eq("rst_memreq_val", memreq_val, 0);
    model_reset();
    memresp_val = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;
    imemreq_msg = mk_req(1'b0, 32'h100, 32'h0); dmemreq_msg = mk_req(1'b1, 32'h200, 32'h55);
    memresp_msg = 35'h7_0000_0001;
    repeat (2) @(posedge clk);
    #4;
    check_eq("reset_memreq_val", memreq_val, 0);
    check_eq("reset_imemreq_rdy", imemreq_rdy, 0);
    check_eq("reset_dmemreq_rdy", dmemreq_rdy, 0);
    check_eq("reset_imemresp_val", imemresp_val, 0);
    check_eq("reset_dmemresp_val", dmemresp_val, 0);
    check_eq("reset_route_err", route_err, 0);
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0; memreq_rdy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (2) cycle();

    // imem only, three reads, memory latency 1
    memreq_rdy = 1'b1; i_resp = 0; d_resp = 0;
    for (int unsigned a = 0; a < 3; a++) iq.push_back(mk_req(1'b0, 32'(a * 4), 32'h0));
    drain();
    check_eq("imem_only_iresp", i_resp, 3);
    check_eq("imem_only_dresp", d_resp, 0);

    // both ports busy every cycle: D,I,D,I...
    ord = '0; i_resp = 0; d_resp = 0;
    for (int unsigned a = 0; a < 4; a++) begin
      iq.push_back(mk_req(1'b0, 32'h1000 + 32'(a * 4), 32'h0));
      dq.push_back(mk_req(1'b1, 32'h2000 + 32'(a * 4), 32'hC0DE_0000 + a));
    end
    drain();
    check_eq("alt_order", ord, 8'b1010_1010);
    check_eq("alt_iresp", i_resp, 4);
    check_eq("alt_dresp", d_resp, 4);

    // responses stalled: FIFO fills, one pop does not bypass full
    budget = 0; fires = 0;
    for (int unsigned a = 0; a < 6; a++) iq.push_back(mk_req(1'b0, 32'h3000 + 32'(a * 4), 32'h0));
    repeat (6) cycle();
    check_eq("full_fires", fires, 4);
    budget = 1;
    cycle();
    check_eq("pop_no_bypass", fires, 4);
    cycle();
    check_eq("fire_after_pop", fires, 5);
    budget = -1;
    drain();

    // imem held by memreq_rdy=0 while dmem raises val
    memreq_rdy = 1'b0; d_en = 1'b0; fires = 0;
    iq.push_back(mk_req(1'b0, 32'h4000, 32'h0));
    dq.push_back(mk_req(1'b1, 32'h5000, 32'hBEEF));
    repeat (2) cycle();
    d_en = 1'b1;
    repeat (3) cycle();
    memreq_rdy = 1'b1;
    cycle();
    check_eq("hold_first_fire", fires, 1);
    check_eq("hold_fire_port", last_fire_d, 0);
    drain();

    // spurious response with nothing outstanding, then async reset
    spur = 1'b1;
    repeat (3) cycle();
    check_eq("spur_err_sticky", route_err, 1);
    do_async_reset();
    cycle();

    // in-flight requests discarded by reset; their late responses are route errors
    budget = 0;
    iq.push_back(mk_req(1'b0, 32'h6000, 32'h0));
    iq.push_back(mk_req(1'b0, 32'h6004, 32'h0));
    repeat (3) cycle();
    do_async_reset();
    budget = -1; i_resp = 0; d_resp = 0;
    repeat (3) cycle();
    check_eq("stale_err", route_err, 1);
    check_eq("stale_no_resp", i_resp + d_resp, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
